pipe_stage_hs: RTL and testbench
================================

Name: pipe_stage_hs

Overview:
- Parametrised, handshaked pipeline-stage register for the five-stage MIPS core. Generalises the fixed IF/ID latch.
- Carries an instruction word, PC and next-PC select field from one stage to the next.
- Uses valid/ready flow control instead of a bare enable. Supports flush, eret-kill and bubble insertion.
- Counts back-pressure cycles. Instantiated at IF/ID; reusable at ID/EX and later stage boundaries.

Parameters:
- IW, 32, instruction/payload width
- PCW, 32, PC width
- SELW, 3, next-PC select width
- PC_RESET, 32'h0000_3000, PC value loaded on reset/flush/kill
- CNT_W, 16, width of stall cycle counter

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat this cycle
- in_instr  in  IW  upstream instruction
- in_pc  in  PCW  upstream PC
- in_sel  in  SELW  upstream next-PC select
- flush  in  1  clear stage (branch/exception squash)
- kill  in  1  convert the beat accepted this cycle into a bubble (eret)
- out_valid  out  1  stage holds a live beat
- out_ready  in  1  downstream accepts beat
- out_instr  out  IW  registered instruction
- out_pc  out  PCW  registered PC
- out_sel  out  SELW  registered select
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Clock and reset: single clock clk; reset synchronous, active-high, named reset.
- Reset values:
  - out_valid=0, out_instr=0, out_pc=PC_RESET, out_sel=0, stall_cnt=0.
  - Skid entry (if built) empty and zeroed.
- Handshake definitions:
  - Accept = in_valid & in_ready at a rising edge.
  - Drain = out_valid & out_ready.
- Priority per edge: reset > flush > kill > normal load/hold.
- Base mode (no skid):
  - in_ready = ~out_valid | out_ready (combinational).
  - On accept: payload registered; out_valid=1 next cycle. Latency 1 cycle.
  - Drain with no accept: out_valid=0; payload registers hold their last value.
  - out_valid=1 and out_ready=0: all outputs hold, bit-exact.
- flush:
  - Next cycle out_valid=0, out_instr=0, out_pc=PC_RESET, out_sel=0; skid cleared.
  - A beat offered in the flush cycle is discarded. Upstream sees a normal accept if in_ready was high.
  - in_ready is not gated by flush.
- kill:
  - Effective only when an accept occurs in the same cycle.
  - Registered result is the bubble: valid=0, instr=0, pc=PC_RESET, sel=0.
  - kill without accept: no effect.
- stall_cnt:
  - +1 each cycle out_valid & ~out_ready.
  - Stops at all-ones; no wrap.
  - Cleared only by reset; flush does not clear it.
- Simultaneous accept and drain: new beat replaces the old one; out_valid stays 1 (full throughput, one beat per cycle).
- Reset asserted mid-stall: all state returns to reset values next cycle; in-flight beat lost.

Optional Feature:
- Macro: PIPE_STAGE_SKID_EN.
- Defined:
  - One-entry skid buffer added.
  - in_ready = ~skid_valid (registered), so there is no combinational path out_ready→in_ready.
  - Accept while out_valid & ~out_ready writes the skid.
  - When the main register drains and skid_valid=1, the main register loads from skid and skid empties.
  - Order is preserved.
  - kill bubbles the entry being written (main or skid).
  - flush empties both entries.
  - Maximum two beats held.
- Undefined: base mode above; no skid storage; combinational in_ready.

Test Plan:
- Reset:
  - Stimulus: reset=1 for 2 cycles with in_valid=1.
  - Response: out_valid=0, out_pc=32'h3000, out_instr=0, stall_cnt=0.
- Streaming:
  - Stimulus: out_ready=1, beats instr=0x8C01_0004/pc=0x3000, 0x0022_1820/0x3004, 0x1000_FFFF/0x3008 on consecutive cycles.
  - Response: each appears 1 cycle later, out_valid continuous.
- Back-pressure:
  - Stimulus: beat 0x2001_0005 accepted, then out_ready=0 for 5 cycles.
  - Response: outputs held; stall_cnt=5; base in_ready=0.
  - With PIPE_STAGE_SKID_EN: one more beat accepted, then in_ready=0; release drains both in order.
- flush during stall:
  - Stimulus: out_valid=1, out_ready=0, flush=1 with in_valid=1.
  - Response: next cycle out_valid=0, out_pc=0x3000; offered beat never appears; stall_cnt not cleared.
- kill:
  - Stimulus: accept of instr=0x4200_0018 with kill=1.
  - Response: out_valid=0, out_instr=0, out_sel=0.
  - Stimulus: kill=1 with in_valid=0.
  - Response: state unchanged.
- Saturation:
  - Stimulus: CNT_W=4, out_ready=0 for 20 cycles with a valid beat.
  - Response: stall_cnt=4'hF, no wrap.

Source files
------------

// File: rtl/pipe_stage_hs.sv
// Handshaked pipeline-stage register carrying instr/PC/next-PC select.
// Optional one-entry skid buffer: define PIPE_STAGE_SKID_EN.
module pipe_stage_hs #(
  parameter int          IW       = 32,
  parameter int          PCW      = 32,
  parameter int          SELW     = 3,
  parameter logic [PCW-1:0] PC_RESET = 32'h0000_3000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IW-1:0]    in_instr,
  input  logic [PCW-1:0]   in_pc,
  input  logic [SELW-1:0]  in_sel,
  input  logic             flush,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IW-1:0]    out_instr,
  output logic [PCW-1:0]   out_pc,
  output logic [SELW-1:0]  out_sel,
  output logic [CNT_W-1:0] stall_cnt
);

  logic accept;
  logic stalled;

  assign stalled = out_valid & ~out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic            skid_valid;
  logic [IW-1:0]   skid_instr;
  logic [PCW-1:0]  skid_pc;
  logic [SELW-1:0] skid_sel;

  assign in_ready = ~skid_valid;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_valid  <= 1'b0;
      out_instr  <= '0;
      out_pc     <= PC_RESET;
      out_sel    <= '0;
      skid_valid <= 1'b0;
      skid_instr <= '0;
      skid_pc    <= PC_RESET;
      skid_sel   <= '0;
    end else if (stalled) begin
      // Main is stuck; a new beat parks in the skid entry.
      if (accept) begin
        skid_valid <= ~kill;
        skid_instr <= kill ? '0 : in_instr;
        skid_pc    <= kill ? PC_RESET : in_pc;
        skid_sel   <= kill ? '0 : in_sel;
      end
    end else if (skid_valid) begin
      out_valid  <= 1'b1;
      out_instr  <= skid_instr;
      out_pc     <= skid_pc;
      out_sel    <= skid_sel;
      skid_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= ~kill;
      out_instr <= kill ? '0 : in_instr;
      out_pc    <= kill ? PC_RESET : in_pc;
      out_sel   <= kill ? '0 : in_sel;
    end else if (out_valid) begin
      out_valid <= 1'b0;
    end
  end
`else
  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= PC_RESET;
      out_sel   <= '0;
    end else if (accept) begin
      out_valid <= ~kill;
      out_instr <= kill ? '0 : in_instr;
      out_pc    <= kill ? PC_RESET : in_pc;
      out_sel   <= kill ? '0 : in_sel;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end
`endif

  // Back-pressure counter survives flush so stalls can be profiled.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stalled && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Randomized + directed bench for pipe_stage_hs against a queue model.
// Works for both the base build and PIPE_STAGE_SKID_EN.
module tb_pipe_stage_hs;

  localparam int CW  = 4;
  localparam logic [31:0] PCR = 32'h0000_3000;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [2:0]  sel;
  } beat_t;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, flush, kill;
  logic out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_instr, out_pc;
  logic [2:0] in_sel, out_sel;
  logic [CW-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  beat_t q[$];
  beat_t last;
  int    cnt;

  always #5 clk = ~clk;

  pipe_stage_hs #(
    .IW(32), .PCW(32), .SELW(3),
    .PC_RESET(PCR), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .in_sel(in_sel), .flush(flush), .kill(kill),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .out_sel(out_sel), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic beat_t bubble();
    beat_t b;
    b.instr = '0;
    b.pc    = PCR;
    b.sel   = '0;
    return b;
  endfunction

  // One cycle: drive, check at negedge, advance model at posedge.
  task automatic cyc(input logic rst, input logic iv,
                     input logic [31:0] ins,
                     input logic [31:0] pc,
                     input logic [2:0] sel,
                     input logic ordy,
                     input logic fl, input logic kl);
    beat_t b, shown;
    bit    rdy, vld;
    reset = rst; in_valid = iv; in_instr = ins;
    in_pc = pc; in_sel = sel; out_ready = ordy;
    flush = fl; kill = kl;
    vld   = q.size() > 0;
    shown = vld ? q[0] : last;
    rdy   = (CAP == 2) ? (q.size() < 2)
                       : (q.size() == 0 || ordy);
    @(negedge clk);
    chk("out_valid", {31'b0, out_valid}, {31'b0, vld});
    chk("out_instr", out_instr, shown.instr);
    chk("out_pc", out_pc, shown.pc);
    chk("out_sel", {29'b0, out_sel}, {29'b0, shown.sel});
    chk("stall_cnt", {28'b0, stall_cnt}, cnt);
    chk("in_ready", {31'b0, in_ready}, {31'b0, rdy});
    @(posedge clk);
    b.instr = ins; b.pc = pc; b.sel = sel;
    if (rst) begin
      q.delete();
      last = bubble();
      cnt  = 0;
    end else begin
      if (vld && !ordy && cnt < (1 << CW) - 1) cnt++;
      if (fl) begin
        q.delete();
        last = bubble();
      end else begin
        if (vld && ordy) last = q.pop_front();
        if (iv && rdy) begin
          if (!kl) q.push_back(b);
          else if (q.size() == 0) last = bubble();
        end
      end
    end
    #1;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b1; in_instr = 32'hDEAD_BEEF;
    in_pc = 32'h1234; in_sel = 3'd5; out_ready = 1'b0;
    flush = 1'b0; kill = 1'b0;
    last = bubble();
    cnt  = 0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    cyc(1, 1, 32'hDEAD_BEEF, 32'h1234, 3'd5, 0, 0, 0);
    // Streaming
    cyc(0, 1, 32'h8C01_0004, 32'h3000, 3'd1, 1, 0, 0);
    cyc(0, 1, 32'h0022_1820, 32'h3004, 3'd2, 1, 0, 0);
    cyc(0, 1, 32'h1000_FFFF, 32'h3008, 3'd3, 1, 0, 0);
    cyc(0, 0, 32'h0, 32'h0, 3'd0, 1, 0, 0);
    cyc(0, 0, 32'h0, 32'h0, 3'd0, 1, 0, 0);
    // Back-pressure, extra beat offered (skid takes it)
    cyc(0, 1, 32'h2001_0005, 32'h300C, 3'd4, 1, 0, 0);
    cyc(0, 1, 32'h2002_0006, 32'h3010, 3'd6, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      cyc(0, 1, 32'h2003_0007, 32'h3014, 3'd7, 0, 0, 0);
    cyc(0, 0, 32'h0, 32'h0, 3'd0, 1, 0, 0);
    cyc(0, 0, 32'h0, 32'h0, 3'd0, 1, 0, 0);
    cyc(0, 0, 32'h0, 32'h0, 3'd0, 1, 0, 0);
    // Flush during stall
    cyc(0, 1, 32'h2004_0008, 32'h3018, 3'd2, 1, 0, 0);
    cyc(0, 0, 32'h0, 32'h0, 3'd0, 0, 0, 0);
    cyc(0, 1, 32'hBAD0_0001, 32'h4444, 3'd5, 0, 1, 0);
    cyc(0, 0, 32'h0, 32'h0, 3'd0, 1, 0, 0);
    cyc(0, 0, 32'h0, 32'h0, 3'd0, 1, 0, 0);
    // kill with accept, then kill alone
    cyc(0, 1, 32'h4200_0018, 32'h3020, 3'd3, 1, 0, 1);
    cyc(0, 1, 32'h0000_0001, 32'h3024, 3'd1, 1, 0, 0);
    cyc(0, 0, 32'h0, 32'h0, 3'd0, 0, 0, 1);
    cyc(0, 0, 32'h0, 32'h0, 3'd0, 0, 0, 1);
    cyc(0, 0, 32'h0, 32'h0, 3'd0, 1, 0, 0);
    // Saturation: 20 stalled cycles
    cyc(0, 1, 32'h2001_0005, 32'h3028, 3'd4, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      cyc(0, 0, 32'h0, 32'h0, 3'd0, 0, 0, 0);
    cyc(0, 0, 32'h0, 32'h0, 3'd0, 1, 0, 0);
    // Reset mid-stall
    cyc(0, 1, 32'h1111_2222, 32'h302C, 3'd1, 0, 0, 0);
    cyc(0, 0, 32'h0, 32'h0, 3'd0, 0, 0, 0);
    cyc(1, 1, 32'h3333_4444, 32'h3030, 3'd2, 0, 0, 0);
    cyc(0, 0, 32'h0, 32'h0, 3'd0, 1, 0, 0);
    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(99) == 0,
          $urandom_range(3) != 0,
          $urandom, $urandom, 3'($urandom),
          $urandom_range(2) != 0,
          $urandom_range(29) == 0,
          $urandom_range(14) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
